// File: rtl/fetch_ctrl_2way.sv
// fetch_ctrl_2way
// Dual-issue fetch controller. Drives the slot-0/slot-1 read addresses of a
// combinational instruction memory and captures each returned pair into a
// small pair FIFO. Decode pulls pairs with a valid/ready handshake. A branch
// redirect flushes the FIFO. Fetch stops at a programmable end address.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   PC           out  slot-0 fetch address
//   PC4          out  slot-1 fetch address (PC + 4)
//   instr1       in   instruction at PC, same cycle
//   instr2       in   instruction at PC4, same cycle
//   branch_en    in   redirect request
//   branch_pc    in   redirect target (low two bits ignored)
//   dec_ready    in   decode accepts the head pair
//   dec_valid    out  FIFO non-empty
//   dec_valid2   out  slot 1 of the head pair is valid
//   dec_pc       out  slot-0 address of the head pair
//   dec_instr1   out  head pair slot-0 instruction
//   dec_instr2   out  head pair slot-1 instruction
//   fifo_count   out  occupied FIFO entries
//   halted       out  controller is in HALT
module fetch_ctrl_2way #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] END_PC   = 64'h180,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [63:0]                PC,
  output logic [63:0]                PC4,
  input  logic [31:0]                instr1,
  input  logic [31:0]                instr2,
  input  logic                       branch_en,
  input  logic [63:0]                branch_pc,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic                       dec_valid2,
  output logic [63:0]                dec_pc,
  output logic [31:0]                dec_instr1,
  output logic [31:0]                dec_instr2,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, REDIRECT, HALT} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [63:0]   mem_pc [DEPTH];
  logic [31:0]   mem_i1 [DEPTH];
  logic [31:0]   mem_i2 [DEPTH];
  logic          mem_v2 [DEPTH];

  logic          full;
  logic          at_end;
  logic          redirect;
  logic          push;
  logic          pop;

  assign PC4        = PC + 64'd4;
  assign fifo_count = count;
  assign dec_valid  = (count != '0);

  assign full     = (count == FULL_CNT);
  assign at_end   = (PC >= END_PC);
  // Redirect wins over push and pop; it is ignored only in the one-cycle IDLE.
  assign redirect = branch_en && (state != IDLE);
  // Fullness is judged on the count at the start of the cycle, so a pop from a
  // full FIFO does not free a slot for a push in the same cycle.
  assign push     = (state == FETCH) && !redirect && !at_end && !full;
  assign pop      = dec_valid && dec_ready && !redirect;

  // Head outputs come straight from the FIFO storage; forced to zero when
  // empty so the reset values are well defined without resetting the array.
  assign dec_pc     = dec_valid ? mem_pc[rd_ptr] : '0;
  assign dec_instr1 = dec_valid ? mem_i1[rd_ptr] : '0;
  assign dec_instr2 = dec_valid ? mem_i2[rd_ptr] : '0;
  assign dec_valid2 = dec_valid && mem_v2[rd_ptr];

  // Control: state machine, fetch address, FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      PC     <= RESET_PC;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      state  <= REDIRECT;
      PC     <= branch_pc & ~64'd3;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE:     state <= FETCH;
        REDIRECT: state <= FETCH;
        FETCH: begin
          if (at_end) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT:     state <= HALT;
        default:  state <= IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        PC     <= PC + 64'd8;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data: pair storage, written on push; stale entries are masked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= PC;
      mem_i1[wr_ptr] <= instr1;
      mem_i2[wr_ptr] <= instr2;
      mem_v2[wr_ptr] <= (PC4 < END_PC);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl_2way.sv
module tb_fetch_ctrl_2way;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] END_PC   = 64'h180;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] PC, PC4;
  logic [31:0] instr1, instr2;
  logic        branch_en = 1'b0;
  logic [63:0] branch_pc = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid, dec_valid2;
  logic [63:0] dec_pc;
  logic [31:0] dec_instr1, dec_instr2;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  assign instr1 = imem(PC);
  assign instr2 = imem(PC4);

  fetch_ctrl_2way #(.RESET_PC(RESET_PC), .END_PC(END_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .PC4(PC4),
    .instr1(instr1), .instr2(instr2),
    .branch_en(branch_en), .branch_pc(branch_pc), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_valid2(dec_valid2), .dec_pc(dec_pc),
    .dec_instr1(dec_instr1), .dec_instr2(dec_instr2),
    .fifo_count(fifo_count), .halted(halted)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched pairs plus the next fetch address.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v2;
  } pair_t;

  pair_t       q[$];
  logic [63:0] mpc;
  bit          m_idle, m_gap, m_halt;

  task automatic model_reset();
    q.delete();
    mpc    = RESET_PC;
    m_idle = 1'b1;
    m_gap  = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic br, input logic [63:0] bpc, input logic rdy);
    pair_t e;
    bit    do_pop, is_full;
    if (br && !m_idle) begin
      q.delete();
      mpc    = bpc & ~64'd3;
      m_gap  = 1'b1;
      m_halt = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && rdy;
      is_full = (q.size() == DEPTH);
      if (m_idle) m_idle = 1'b0;
      else if (m_gap) m_gap = 1'b0;
      else if (!m_halt) begin
        if (mpc >= END_PC) m_halt = 1'b1;
        else if (!is_full) begin
          e.pc = mpc;
          e.i1 = imem(mpc);
          e.i2 = imem(mpc + 64'd4);
          e.v2 = ((mpc + 64'd4) < END_PC);
          q.push_back(e);
          mpc = mpc + 64'd8;
        end
      end
      if (do_pop) q.delete(0);
    end
  endtask

  task automatic model_check();
    chk("pc", PC, mpc);
    chk("pc4", PC4, mpc + 64'd4);
    chk("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("halted", 64'(halted), 64'(m_halt));
    if (q.size() != 0) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_instr1", 64'(dec_instr1), 64'(q[0].i1));
      chk("dec_valid2", 64'(dec_valid2), 64'(q[0].v2));
      if (q[0].v2) chk("dec_instr2", 64'(dec_instr2), 64'(q[0].i2));
    end
  endtask

  task automatic tick(input logic br, input logic [63:0] bpc, input logic rdy);
    branch_en = br;
    branch_pc = bpc;
    dec_ready = rdy;
    @(posedge clk);
    model_step(br, bpc, rdy);
    #1;
    model_check();
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    branch_en = 1'b0;
    branch_pc = '0;
    dec_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", PC, RESET_PC);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_valid2", 64'(dec_valid2), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_instr1", 64'(dec_instr1), 64'd0);
    chk("rst_instr2", 64'(dec_instr2), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [63:0] dpc;
    int          cnt;
    logic [63:0] fpc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Fill-then-drain from reset: dec_ready low for 10 edges, then high.
    tbl[0]  = '{1'b0, 1'b0, 64'h00, 0, 64'h00};
    tbl[1]  = '{1'b0, 1'b1, 64'h00, 1, 64'h08};
    tbl[2]  = '{1'b0, 1'b1, 64'h00, 2, 64'h10};
    tbl[3]  = '{1'b0, 1'b1, 64'h00, 3, 64'h18};
    tbl[4]  = '{1'b0, 1'b1, 64'h00, 4, 64'h20};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 64'h00, 4, 64'h20};
    tbl[10] = '{1'b1, 1'b1, 64'h08, 3, 64'h20};
    tbl[11] = '{1'b1, 1'b1, 64'h10, 3, 64'h28};
    tbl[12] = '{1'b1, 1'b1, 64'h18, 3, 64'h30};
    tbl[13] = '{1'b1, 1'b1, 64'h20, 3, 64'h38};
    tbl[14] = '{1'b1, 1'b1, 64'h28, 3, 64'h40};

    do_reset();

    // Streaming from reset with decode always ready.
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, '0, 1'b1);
      if (k >= 2) begin
        chk("stream_valid", 64'(dec_valid), 64'd1);
        chk("stream_pc", dec_pc, 64'(8 * (k - 2)));
        chk("stream_i1", 64'(dec_instr1), 64'(imem(64'(8 * (k - 2)))));
        chk("stream_i2", 64'(dec_instr2), 64'(imem(64'(8 * (k - 2) + 4))));
      end else begin
        chk("stream_idle_valid", 64'(dec_valid), 64'd0);
      end
    end

    // Table-driven fill and drain.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, '0, tbl[i].rdy);
      chk("tbl_valid", 64'(dec_valid), 64'(tbl[i].vld));
      chk("tbl_count", 64'(fifo_count), 64'(tbl[i].cnt));
      chk("tbl_fetch_pc", PC, tbl[i].fpc);
      chk("tbl_halted", 64'(halted), 64'd0);
      if (tbl[i].vld) begin
        chk("tbl_dec_pc", dec_pc, tbl[i].dpc);
        chk("tbl_instr1", 64'(dec_instr1), 64'(imem(tbl[i].dpc)));
      end
    end

    // Redirect to 0x54 with three entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    chk("rd_pre_count", 64'(fifo_count), 64'd3);
    tick(1'b1, 64'h54, 1'b0);
    chk("rd_count", 64'(fifo_count), 64'd0);
    chk("rd_valid0", 64'(dec_valid), 64'd0);
    chk("rd_pc", PC, 64'h54);
    tick(1'b0, '0, 1'b1);
    chk("rd_valid1", 64'(dec_valid), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("rd_valid2", 64'(dec_valid), 64'd1);
    chk("rd_dec_pc", dec_pc, 64'h54);
    chk("rd_i1", 64'(dec_instr1), 64'(imem(64'h54)));
    chk("rd_i2", 64'(dec_instr2), 64'(imem(64'h58)));

    // Redirect near the end address, halt, then resume from 0.
    tick(1'b1, 64'h17F, 1'b1);
    chk("end_pc", PC, 64'h17C);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("end_valid", 64'(dec_valid), 64'd1);
    chk("end_dec_pc", dec_pc, 64'h17C);
    chk("end_valid2", 64'(dec_valid2), 64'd0);
    chk("end_not_halted", 64'(halted), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("end_halted", 64'(halted), 64'd1);
    chk("end_drained", 64'(dec_valid), 64'd0);
    tick(1'b0, '0, 1'b1);
    chk("end_still_halted", 64'(halted), 64'd1);
    tick(1'b1, 64'h0, 1'b1);
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_pc", PC, 64'h0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("resume_dec_pc", dec_pc, 64'h0);
    chk("resume_valid", 64'(dec_valid), 64'd1);

    // Full FIFO, pop and redirect in the same cycle.
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0);
    chk("full_count", 64'(fifo_count), 64'd4);
    tick(1'b1, 64'h100, 1'b1);
    chk("fb_count", 64'(fifo_count), 64'd0);
    chk("fb_valid", 64'(dec_valid), 64'd0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("fb_dec_pc", dec_pc, 64'h100);
    chk("fb_valid_back", 64'(dec_valid), 64'd1);

    // Reset with two entries queued, then reset during a REDIRECT cycle.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
    chk("two_queued", 64'(fifo_count), 64'd2);
    do_reset();
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("restart_pc", dec_pc, RESET_PC);
    tick(1'b1, 64'h40, 1'b0);
    do_reset();
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("restart2_pc", dec_pc, RESET_PC);
    chk("restart2_valid", 64'(dec_valid), 64'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic        br, rdy;
      logic [63:0] bpc;
      br  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) bpc = {$urandom, $urandom};
      else bpc = 64'($urandom_range(0, 32'h1A0));
      tick(br, bpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_2way.md
# fetch_ctrl_2way

Dual-issue fetch controller for the 2-way superscalar core. Drives the `PC`/`PC4` read addresses of the combinational instruction memory and captures each returned instruction pair into a small pair FIFO. Presents pairs to decode with a valid/ready handshake. Handles branch redirect with a FIFO flush and stops fetching at a programmable end address.

## Interface
- `RESET_PC`, 64'h0: fetch address after reset.
- `END_PC`, 64'h180: the fetch limit; a slot whose address is >= `END_PC` is not fetched.
- `DEPTH`, 4: pair-FIFO entries; must be a power of 2, >= 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC`  out  64  slot-0 fetch address to instruction memory.
- `PC4`  out  64  slot-1 fetch address; always `PC + 4` (combinational).
- `instr1`  in  32  instruction at `PC`, valid in the same cycle.
- `instr2`  in  32  instruction at `PC4`, valid in the same cycle.
- `branch_en`  in  1  redirect request.
- `branch_pc`  in  64  redirect target; bits [1:0] are forced to 0.
- `dec_ready`  in  1  decode accepts the head pair.
- `dec_valid`  out  1  FIFO non-empty.
- `dec_valid2`  out  1  slot 1 of the head pair is valid.
- `dec_pc`  out  64  slot-0 address of the head pair.
- `dec_instr1`, `dec_instr2`  out  32 each  head pair instructions.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries.
- `halted`  out  1  controller is in HALT.

## Operation
- States:
  - IDLE: entered on reset; lasts exactly one cycle, with no push; then goes to FETCH.
  - FETCH: the working state.
  - REDIRECT: one cycle with no push; then goes to FETCH.
  - HALT: stays in HALT until `branch_en`.
- FETCH, no redirect:
  - If `PC >= END_PC`: no push; go to HALT.
  - Otherwise, if `fifo_count < DEPTH` (registered value from the start of the cycle): push {`PC`, `instr1`, `instr2`, v2 = (`PC4 < END_PC`)}, then `PC <= PC + 8`.
  - If the FIFO is full: no push, and `PC` holds.
- Pop: occurs when `dec_valid & dec_ready`.
  - Push and pop may occur in the same cycle; the count is then unchanged.
  - A pop from a full FIFO does not enable a push in that same cycle. There is no bypass.
- Redirect: `branch_en=1` in any state other than IDLE has priority over push and pop. In that cycle:
  - `PC <= {branch_pc[63:2], 2'b00}`.
  - The FIFO is flushed (pointers and count go to 0).
  - State goes to REDIRECT.
  - A pop by decode in that cycle is discarded.
- `branch_en` during IDLE is ignored.
- `branch_en` in HALT leaves HALT through REDIRECT.
- A target with bit 2 set is legal; pairs are not required to be 8-aligned.
- Dequeued slot-1 data is don't-care when `dec_valid2=0`.
- Arithmetic: `PC` increments are modulo 2^64 with no overflow flag. The comparisons against `END_PC` are unsigned.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - `PC=RESET_PC`, state IDLE.
  - `fifo_count=0`, `dec_valid=0`, `dec_valid2=0`, `halted=0`.
  - `dec_pc`, `dec_instr1`, `dec_instr2` = 0.
- Reset asserted mid-operation: all state returns to the reset values immediately and the FIFO contents are discarded.
- Startup: the first rising edge after `rst_n` rises leaves IDLE. The second edge pushes the pair at `RESET_PC`, and `dec_valid=1` after that edge.
- Fetch-to-decode latency is 1 cycle. The head outputs are driven from FIFO registers.
- Redirect sequence, counting from the edge that samples `branch_en`:
  - `dec_valid=0` after that edge.
  - The next edge is the REDIRECT cycle, with no push.
  - The following edge pushes the target pair, and `dec_valid` returns to 1.
  - The redirect penalty is 2 empty cycles.
- Steady state with `dec_ready=1`: one pair per cycle.
- With `dec_ready=0`: the FIFO fills in `DEPTH` cycles, then `PC` stalls.
- `halted` rises on the edge after the cycle in which FETCH sees `PC >= END_PC`. Entries already in the FIFO still drain normally.

## Test plan
- Reset with `RESET_PC=0`, `dec_ready=1`: `dec_pc` sequence is 0x0, 0x8, 0x10… one per cycle, starting on the 2nd edge after reset release; `dec_instr1`/`dec_instr2` match memory at `PC`/`PC+4`.
- `dec_ready=0` for 10 cycles from reset: `fifo_count` saturates at 4 and `PC` holds at 0x20. Then `dec_ready=1`: pairs drain in order 0x0…0x18, then 0x20 follows with no gap.
- `branch_en=1`, `branch_pc=0x54` while the FIFO holds 3 entries: `fifo_count=0` next cycle, `dec_valid=0` for 2 cycles, then `dec_pc=0x54`, `dec_instr1` = instruction at 0x54, `dec_instr2` = instruction at 0x58.
- `END_PC=0x180`, redirect to 0x17C: one pair pushed with `dec_valid2=0`, then `halted=1`. A later `branch_en` to 0x0 clears `halted` and resumes fetching from 0x0.
- Full FIFO with `dec_ready=1` and `branch_en=1` in the same cycle: the pop is discarded, the FIFO is empty, and the target is fetched.
- `rst_n` pulsed low while 2 entries are queued and in the middle of a redirect: all outputs return to reset values asynchronously, and fetch restarts at `RESET_PC`.
